ex_alu_fwd_access: RTL and testbench
====================================

EX_ALU_FWD_ACCESS -- requirements
Module: ex_alu_fwd_access

Interface
REQ-001 SHALL have these parameters: none; all widths fixed (32-bit datapath, 5-bit register numbers).
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rs, rt  in  5 each  source register numbers.
- rd1, rd2  in  32 each  register-file read data.
- ext_imm  in  32  extended immediate.
- alu_src  in  1  1: ALU B is ext_imm; 0: ALU B is f_rd2.
- aluop  in  4  ALU function.
- sa  in  5  shift amount.
- mem_we, mem_rw  in  1/5  MEM-stage write-back enable and destination.
- mem_wd  in  32  MEM-stage write-back data.
- wb_we, wb_rw  in  1/5  WB-stage write-back enable and destination.
- wb_wd  in  32  WB-stage write-back data.
- use_mem_back, use_wb_back  in  1 each  per-source forwarding enables.
- mem_write, is_byte, is_half  in  1 each  store request and size.
- br_rdata  in  32  bridge read data.
- f_rd1, f_rd2  out  32 each  forwarded operands.
- alu_c  out  32  ALU result.
- sum  out  32  f_rd1 + ALU B.
- zero  out  1  alu_c == 0.
- br_addr  out  32  bridge address.
- br_wdata  out  32  bridge write data.
- br_be  out  4  bridge byte enables.
- br_we  out  1  bridge write strobe.
- dm_out  out  32  registered read data.

Function
REQ-003 Forwarding SHALL be combinational: f_rd1 = mem_wd if use_mem_back & mem_we & mem_rw!=0 & mem_rw==rs; else wb_wd if use_wb_back & wb_we & wb_rw!=0 & wb_rw==rs; else rd1. f_rd2 SHALL be identical using rt and rd2.
REQ-004 When MEM and WB both match, MEM SHALL win. Register 0 SHALL never be forwarded.
REQ-005 ALU operands SHALL be A = f_rd1 and B = (alu_src ? ext_imm : f_rd2).
REQ-006 aluop encoding SHALL be:
- 0 A+B; 1 A-B; 2 AND; 3 OR; 4 XOR; 5 NOR.
- 6 signed A<B (result 1 or 0); 7 unsigned A<B (result 1 or 0).
- 8 B<<sa; 9 B>>sa logical; 10 B>>>sa arithmetic.
- 11 B<<A[4:0]; 12 B>>A[4:0] logical; 13 B>>>A[4:0] arithmetic.
- 14 B<<16; 15 pass B.
REQ-007 Add and subtract SHALL wrap modulo 2^32. There SHALL be no overflow flag or trap.
REQ-008 sum SHALL always equal A+B mod 2^32, independent of aluop. zero SHALL be 1 exactly when alu_c is 0.
REQ-009 br_addr SHALL equal sum. br_we SHALL equal mem_write (combinational).
REQ-010 Store lanes SHALL be selected as follows:
- Byte (is_byte=1): br_be = 1 << sum[1:0]; br_wdata = f_rd2[7:0] replicated 4 times.
- Half (is_half=1, is_byte=0): br_be = sum[1] ? 1100 : 0011; br_wdata = f_rd2[15:0] replicated twice; sum[0] is ignored.
- Word (otherwise): br_be = 1111; br_wdata = f_rd2; sum[1:0] are ignored.
REQ-011 When mem_write=0, br_be SHALL be 0000. br_wdata is don't-care but SHALL still follow REQ-010.
REQ-012 If is_byte and is_half are both 1, byte SHALL take precedence.
REQ-013 dm_out SHALL capture br_rdata on every rising clk edge, giving 1-cycle latency. Loads SHALL be passed unmodified; lane extraction is done downstream.
REQ-014 All paths except dm_out SHALL be purely combinational. There is no state machine.

Reset
REQ-015 rst low SHALL asynchronously clear dm_out to 0. dm_out SHALL stay 0 while rst is low.
REQ-016 Combinational outputs SHALL be unaffected by rst.
REQ-017 dm_out SHALL resume capturing on the first rising clk edge after rst deasserts.

Verification
REQ-018 A bench SHALL cover at least these directed scenarios:
- Forwarding priority: rs=5, rd1=1, MEM (we=1, rw=5, wd=0xAA) and WB (we=1, rw=5, wd=0xBB) both active -> f_rd1=0xAA; with use_mem_back=0 -> 0xBB; with rs=0 and both rw=0 -> rd1.
- Shifts and compares: aluop=10, B=0x80000000, sa=4 -> 0xF8000000. aluop=6, A=0xFFFFFFFF, B=1 -> 1. aluop=7, same operands -> 0.
- Subtract: aluop=1, A=B=0x1234 -> alu_c=0, zero=1. aluop=0, A=0xFFFFFFFF, B=2 -> 1 (wrap).
- Byte store: mem_write=1, is_byte=1, A=0x1000, ext_imm=3, alu_src=1, f_rd2=0x12345678 -> br_addr=0x1003, br_be=1000, br_wdata=0x78787878, br_we=1.
- Half store: mem_write=1, is_half=1, sum=0x2002 -> br_be=1100, br_wdata=0x56785678.
- Read capture and reset: br_rdata=0xDEADBEEF with a clk edge -> dm_out=0xDEADBEEF next cycle; rst pulsed low mid-cycle -> dm_out=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/ex_alu_fwd_access.sv
// ex_alu_fwd_access: execute stage with operand forwarding, ALU, store-lane steering and registered load data
module ex_alu_fwd_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] ext_imm,
    input  logic        alu_src,
    input  logic [3:0]  aluop,
    input  logic [4:0]  sa,
    input  logic        mem_we,
    input  logic [4:0]  mem_rw,
    input  logic [31:0] mem_wd,
    input  logic        wb_we,
    input  logic [4:0]  wb_rw,
    input  logic [31:0] wb_wd,
    input  logic        use_mem_back,
    input  logic        use_wb_back,
    input  logic        mem_write,
    input  logic        is_byte,
    input  logic        is_half,
    input  logic [31:0] br_rdata,
    output logic [31:0] f_rd1,
    output logic [31:0] f_rd2,
    output logic [31:0] alu_c,
    output logic [31:0] sum,
    output logic        zero,
    output logic [31:0] br_addr,
    output logic [31:0] br_wdata,
    output logic [3:0]  br_be,
    output logic        br_we,
    output logic [31:0] dm_out
);
    logic        mem_ok;
    logic        wb_ok;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  lane_be;

    assign mem_ok = use_mem_back & mem_we & (mem_rw != 5'd0);
    assign wb_ok  = use_wb_back & wb_we & (wb_rw != 5'd0);

    // Forward the youngest in-flight result; MEM is newer than WB, r0 never forwards
    always_comb begin
        f_rd1 = (mem_ok && mem_rw == rs) ? mem_wd : (wb_ok && wb_rw == rs) ? wb_wd : rd1;
        f_rd2 = (mem_ok && mem_rw == rt) ? mem_wd : (wb_ok && wb_rw == rt) ? wb_wd : rd2;
    end

    assign a     = f_rd1;
    assign b     = alu_src ? ext_imm : f_rd2;
    assign sum   = a + b;
    assign zero  = (alu_c == 32'd0);

    // ALU function select; add/sub wrap silently with no overflow detection
    always_comb begin
        case (aluop)
            4'd0:    alu_c = a + b;
            4'd1:    alu_c = a - b;
            4'd2:    alu_c = a & b;
            4'd3:    alu_c = a | b;
            4'd4:    alu_c = a ^ b;
            4'd5:    alu_c = ~(a | b);
            4'd6:    alu_c = {31'd0, $signed(a) < $signed(b)};
            4'd7:    alu_c = {31'd0, a < b};
            4'd8:    alu_c = b << sa;
            4'd9:    alu_c = b >> sa;
            4'd10:   alu_c = $signed(b) >>> sa;
            4'd11:   alu_c = b << a[4:0];
            4'd12:   alu_c = b >> a[4:0];
            4'd13:   alu_c = $signed(b) >>> a[4:0];
            4'd14:   alu_c = b << 16;
            default: alu_c = b;
        endcase
    end

    assign br_addr = sum;
    assign br_we   = mem_write;

    // Steer store data into lanes; byte wins over half when both are requested
    always_comb begin
        lane_be  = is_byte ? (4'b0001 << sum[1:0]) : is_half ? (sum[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        br_be    = mem_write ? lane_be : 4'b0000;
        br_wdata = is_byte ? {4{f_rd2[7:0]}} : is_half ? {2{f_rd2[15:0]}} : f_rd2;
    end

    // Register bridge read data unmodified; lane extraction happens downstream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dm_out <= 32'd0;
        else      dm_out <= br_rdata;
    end
endmodule

// File: tb/tb_ex_alu_fwd_access.sv
// tb_ex_alu_fwd_access: directed vectors checked by a behavioural model every cycle plus literal expectations
module tb_ex_alu_fwd_access;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs, rt, sa, mem_rw, wb_rw;
    logic [31:0] rd1, rd2, ext_imm, mem_wd, wb_wd, br_rdata;
    logic        alu_src, mem_we, wb_we, use_mem_back, use_wb_back, mem_write, is_byte, is_half;
    logic [3:0]  aluop;
    logic [31:0] f_rd1, f_rd2, alu_c, sum, br_addr, br_wdata, dm_out;
    logic        zero, br_we;
    logic [3:0]  br_be;
    int          total = 0;
    int          bad = 0;
    logic        run = 1'b0;
    logic [31:0] exp_dm = 32'd0;

    ex_alu_fwd_access dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rd1(rd1), .rd2(rd2), .ext_imm(ext_imm),
        .alu_src(alu_src), .aluop(aluop), .sa(sa), .mem_we(mem_we), .mem_rw(mem_rw),
        .mem_wd(mem_wd), .wb_we(wb_we), .wb_rw(wb_rw), .wb_wd(wb_wd),
        .use_mem_back(use_mem_back), .use_wb_back(use_wb_back), .mem_write(mem_write),
        .is_byte(is_byte), .is_half(is_half), .br_rdata(br_rdata), .f_rd1(f_rd1),
        .f_rd2(f_rd2), .alu_c(alu_c), .sum(sum), .zero(zero), .br_addr(br_addr),
        .br_wdata(br_wdata), .br_be(br_be), .br_we(br_we), .dm_out(dm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] rd);
        if (r == 5'd0) return rd;
        if (use_mem_back && mem_we && mem_rw == r) return mem_wd;
        if (use_wb_back && wb_we && wb_rw == r) return wb_wd;
        return rd;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int n;
        logic [31:0] lr;
        n  = (op >= 4'd8 && op <= 4'd10) ? int'(sa) : int'(x[4:0]);
        lr = y >> n;
        case (op)
            4'd0: return x + y;
            4'd1: return x + ~y + 32'd1;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return ~x & ~y;
            4'd6: return (x[31] != y[31]) ? {31'd0, x[31]} : {31'd0, x < y};
            4'd7: return {31'd0, x < y};
            4'd8, 4'd11: return y << n;
            4'd9, 4'd12: return lr;
            4'd10, 4'd13: return y[31] ? (lr | ~(32'hFFFF_FFFF >> n)) : lr;
            4'd14: return {y[15:0], 16'd0};
            default: return y;
        endcase
    endfunction

    // Reference copy of the load register
    always @(posedge clk or negedge rst) exp_dm = !rst ? 32'd0 : br_rdata;

    // Model-based compare of every output on each falling edge
    always @(negedge clk) begin
        logic [31:0] ea, eb, es, ew;
        logic [3:0]  ebe;
        if (run) begin
            ea = m_fwd(rs, rd1);
            eb = alu_src ? ext_imm : m_fwd(rt, rd2);
            es = ea + eb;
            for (int i = 0; i < 4; i++) begin
                ebe[i] = is_byte ? (i == int'(es[1:0])) : is_half ? ((i / 2) == int'(es[1])) : 1'b1;
                ew[i*8 +: 8] = is_byte ? m_fwd(rt, rd2)[7:0] : is_half ? m_fwd(rt, rd2)[(i%2)*8 +: 8] : m_fwd(rt, rd2)[i*8 +: 8];
            end
            chk("m_f_rd1", f_rd1, ea);
            chk("m_f_rd2", f_rd2, m_fwd(rt, rd2));
            chk("m_alu_c", alu_c, m_alu(aluop, ea, eb));
            chk("m_sum", sum, es);
            chk("m_zero", {31'd0, zero}, {31'd0, m_alu(aluop, ea, eb) == 32'd0});
            chk("m_br_addr", br_addr, es);
            chk("m_br_wdata", br_wdata, ew);
            chk("m_br_be", {28'd0, br_be}, {28'd0, mem_write ? ebe : 4'b0000});
            chk("m_br_we", {31'd0, br_we}, {31'd0, mem_write});
            chk("m_dm_out", dm_out, exp_dm);
        end
    end

    task automatic clear;
        rs = 0; rt = 0; sa = 0; mem_rw = 0; wb_rw = 0; rd1 = 0; rd2 = 0; ext_imm = 0;
        mem_wd = 0; wb_wd = 0; alu_src = 0; mem_we = 0; wb_we = 0; use_mem_back = 1;
        use_wb_back = 1; mem_write = 0; is_byte = 0; is_half = 0; aluop = 0;
    endtask

    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    initial begin
        clear();
        br_rdata = 32'h0;
        #2 rst = 1'b0;
        settle();
        chk("reset_dm", dm_out, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        run = 1'b1;
        rs = 5; rd1 = 1; mem_we = 1; mem_rw = 5; mem_wd = 32'hAA; wb_we = 1; wb_rw = 5; wb_wd = 32'hBB;
        settle();
        chk("fwd_mem_wins", f_rd1, 32'hAA);
        use_mem_back = 0;
        settle();
        chk("fwd_wb", f_rd1, 32'hBB);
        rs = 0; mem_rw = 0; wb_rw = 0; use_mem_back = 1;
        settle();
        chk("fwd_r0", f_rd1, 32'h1);
        rt = 7; rd2 = 32'h55; wb_rw = 7; wb_wd = 32'hCAFE;
        settle();
        chk("fwd_rt_wb", f_rd2, 32'hCAFE);
        clear();
        aluop = 10; alu_src = 1; ext_imm = 32'h8000_0000; sa = 4;
        settle();
        chk("sra", alu_c, 32'hF800_0000);
        aluop = 6; rd1 = 32'hFFFF_FFFF; ext_imm = 1;
        settle();
        chk("slt", alu_c, 32'd1);
        aluop = 7;
        settle();
        chk("sltu", alu_c, 32'd0);
        chk("sltu_zero", {31'd0, zero}, 32'd1);
        aluop = 1; rd1 = 32'h1234; ext_imm = 32'h1234;
        settle();
        chk("sub", alu_c, 32'd0);
        chk("sub_zero", {31'd0, zero}, 32'd1);
        aluop = 0; rd1 = 32'hFFFF_FFFF; ext_imm = 2;
        settle();
        chk("add_wrap", alu_c, 32'd1);
        chk("add_nz", {31'd0, zero}, 32'd0);
        for (int op = 0; op < 16; op++) begin
            aluop = 4'(op); alu_src = 0; rt = 3; rd2 = 32'h8123_4567; rd1 = 32'h0000_0F09; sa = 5'd7;
            settle();
        end
        clear();
        mem_write = 1; is_byte = 1; rd1 = 32'h1000; ext_imm = 3; alu_src = 1; rd2 = 32'h1234_5678;
        settle();
        chk("byte_addr", br_addr, 32'h1003);
        chk("byte_be", {28'd0, br_be}, 32'h8);
        chk("byte_wdata", br_wdata, 32'h7878_7878);
        chk("byte_we", {31'd0, br_we}, 32'd1);
        is_byte = 0; is_half = 1; rd1 = 32'h2000; ext_imm = 2;
        settle();
        chk("half_be", {28'd0, br_be}, 32'hC);
        chk("half_wdata", br_wdata, 32'h5678_5678);
        ext_imm = 1;
        settle();
        chk("half_lo_be", {28'd0, br_be}, 32'h3);
        is_byte = 1;
        settle();
        chk("byte_prec_be", {28'd0, br_be}, 32'h2);
        is_byte = 0; is_half = 0; ext_imm = 2;
        settle();
        chk("word_be", {28'd0, br_be}, 32'hF);
        chk("word_wdata", br_wdata, 32'h1234_5678);
        mem_write = 0;
        settle();
        chk("nowrite_be", {28'd0, br_be}, 32'h0);
        chk("nowrite_we", {31'd0, br_we}, 32'd0);
        br_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 br_rdata = 32'h1111_2222;
        chk("dm_capture", dm_out, 32'hDEAD_BEEF);
        #2 rst = 1'b0;
        #1 chk("dm_async_clr", dm_out, 32'd0);
        settle();
        chk("dm_hold_rst", dm_out, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        chk("dm_still_rst", dm_out, 32'd0);
        @(posedge clk);
        #1 chk("dm_resume", dm_out, 32'h1111_2222);
        settle();
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
